// File: rtl/rega_pkg.sv
// Shared types and helpers for the multi-zone irrigation controller.
package rega_pkg;

  typedef enum logic [1:0] {CRIT = 2'd0, BAIXO = 2'd1, MEDIO = 2'd2, ALTO = 2'd3} level_t;
  typedef enum logic [1:0] {IDLE, OPEN, WATER, CLOSE} state_t;
  typedef enum logic {ASPERSAO = 1'b0, GOTEJAMENTO = 1'b1} mode_t;

  typedef struct packed {
    logic   valid;
    level_t lvl;
  } level_dec_t;

  // Thermometer code {H,M,L}; anything non-thermometer is a sensor fault.
  function automatic level_dec_t decode_hml(input logic [2:0] hml);
    level_dec_t d;
    d.valid = 1'b1;
    d.lvl   = CRIT;
    case (hml)
      3'b000:  d.lvl = CRIT;
      3'b001:  d.lvl = BAIXO;
      3'b011:  d.lvl = MEDIO;
      3'b111:  d.lvl = ALTO;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic level_ok(input level_t lv, input logic drip);
    return drip ? (lv >= BAIXO) : (lv >= MEDIO);
  endfunction

endpackage

// File: rtl/rega_multizona_debounce_sync.sv
// Two-flop synchroniser followed by a stable-count debouncer for one input bit.
module debounce_sync #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Any cycle where the synchronised value agrees with the output restarts the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (s2 == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      dout <= s2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rega_multizona.sv
// Shared-tank irrigation controller: level decode, fill/alarm control and a
// round-robin zone sequencer (open settle, pump, close settle).
module rega_multizona
  import rega_pkg::*;
#(
  parameter int N_ZONES       = 4,
  parameter int DEB_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int WATER_CYCLES  = 1000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       H,
  input  logic                       M,
  input  logic                       L,
  input  logic [N_ZONES-1:0]         Us,
  input  logic [N_ZONES-1:0]         T,
  output logic                       Ve,
  output logic                       Al,
  output logic                       Bs,
  output logic                       Vs,
  output logic [N_ZONES-1:0]         zone_valve,
  output logic [$clog2(N_ZONES)-1:0] active_zone,
  output logic [1:0]                 level,
  output logic                       err,
  output logic                       busy
);

  localparam int ZW   = $clog2(N_ZONES);
  localparam int NB   = 3 + 2 * N_ZONES;
  localparam int CMAX = (SETTLE_CYCLES > WATER_CYCLES) ? SETTLE_CYCLES : WATER_CYCLES;
  localparam int CNTW = $clog2(CMAX + 1);
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE_CYCLES - 1);
  localparam logic [CNTW-1:0] WATER_LAST  = CNTW'(WATER_CYCLES - 1);
  localparam logic [CNTW-1:0] CNT_MAX     = CNTW'(CMAX);

  // Reset asserts asynchronously but is released only after two clean clock edges.
  logic [1:0] rst_pipe;
  logic       rst_int_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_int_n = rst_pipe[1];

  logic [NB-1:0]      raw_bits, deb_bits;
  logic [2:0]         hml_db;
  logic [N_ZONES-1:0] us_db, t_db;

  assign raw_bits = {T, Us, H, M, L};

  for (genvar b = 0; b < NB; b++) begin : g_deb
    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clock   (clock),
      .reset_n (rst_int_n),
      .din     (raw_bits[b]),
      .dout    (deb_bits[b])
    );
  end

  assign hml_db = deb_bits[2:0];
  assign us_db  = deb_bits[3 +: N_ZONES];
  assign t_db   = deb_bits[3 + N_ZONES +: N_ZONES];

  level_dec_t dec;
  level_t     level_q, level_nx;
  logic       err_q, ve_q, ve_nx, al_q;

  // A faulty code freezes the level; the fill valve only changes at the band edges.
  always_comb begin
    dec      = decode_hml(hml_db);
    level_nx = dec.valid ? dec.lvl : level_q;
    ve_nx    = ve_q;
    if (!dec.valid)             ve_nx = 1'b0;
    else if (dec.lvl <= BAIXO)  ve_nx = 1'b1;
    else if (dec.lvl == ALTO)   ve_nx = 1'b0;
  end

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      level_q <= CRIT;
      err_q   <= 1'b0;
      ve_q    <= 1'b0;
      al_q    <= 1'b1;
    end else begin
      level_q <= level_nx;
      err_q   <= ~dec.valid;
      ve_q    <= ve_nx;
      al_q    <= (level_nx == CRIT) | ~dec.valid;
    end
  end

  state_t             state_q, state_nx;
  mode_t              mode_q, mode_nx;
  logic [ZW-1:0]      zone_q, zone_nx, last_q, last_nx, cand, pick;
  logic [CNTW-1:0]    cnt_q;
  logic [N_ZONES-1:0] eligible;
  logic               found, water_abort;

  always_comb begin
    for (int i = 0; i < N_ZONES; i++)
      eligible[i] = us_db[i] & ~err_q & level_ok(level_q, t_db[i]);
  end

  // Search starts just after the last served zone so every bed gets its turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= N_ZONES; k++) begin
      cand = ZW'((int'(last_q) + k) % N_ZONES);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // The running visit judges the tank against the mode latched at its start.
  assign water_abort = ~us_db[zone_q] | err_q | ~level_ok(level_q, mode_q == GOTEJAMENTO);

  always_comb begin
    state_nx = state_q;
    zone_nx  = zone_q;
    mode_nx  = mode_q;
    last_nx  = last_q;
    case (state_q)
      IDLE: if (found) begin
        state_nx = OPEN;
        zone_nx  = pick;
        mode_nx  = t_db[pick] ? GOTEJAMENTO : ASPERSAO;
      end
      OPEN:  if (cnt_q == SETTLE_LAST) state_nx = WATER;
      WATER: if (cnt_q == WATER_LAST || water_abort) state_nx = CLOSE;
      CLOSE: if (cnt_q == SETTLE_LAST) begin
        state_nx = IDLE;
        last_nx  = zone_q;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      zone_q  <= '0;
      mode_q  <= ASPERSAO;
      last_q  <= ZW'(N_ZONES - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      zone_q  <= zone_nx;
      mode_q  <= mode_nx;
      last_q  <= last_nx;
      if (state_nx != state_q)  cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    zone_valve = '0;
    if (busy) zone_valve[zone_q] = 1'b1;
    active_zone = busy ? zone_q : '0;
    Bs          = (state_q == WATER) && (mode_q == ASPERSAO);
    Vs          = (state_q == WATER) && (mode_q == GOTEJAMENTO);
  end

  assign level = level_q;
  assign err   = err_q;
  assign Ve    = ve_q;
  assign Al    = al_q;

endmodule

// File: tb/tb_rega_multizona.sv
// Directed plus randomized bench for rega_multizona, checked every cycle
// against a visit-level behavioural model of the controller.
module tb_rega_multizona;

  localparam int N      = 4;
  localparam int DEB    = 4;
  localparam int SETTLE = 2;
  localparam int WATER  = 10;
  localparam int NB     = 2 * N + 3;

  logic         clock;
  logic         reset_n = 1'b1;
  logic         H, M, L;
  logic [N-1:0] Us, T;
  logic         Ve, Al, Bs, Vs, err, busy;
  logic [N-1:0] zone_valve;
  logic [1:0]   active_zone, level;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: sensor pipeline, decoded tank, and the current visit.
  logic [NB-1:0] m_pipe [$];
  logic [NB-1:0] m_db;
  int            m_diff [NB];
  int            m_lvl;
  bit            m_err, m_ve, m_al;
  bit            m_busy, m_drip;
  int            m_zone, m_last, m_age, m_wend, m_rel;

  int valid_codes [4] = '{0, 1, 3, 7};

  rega_multizona #(
    .N_ZONES(N), .DEB_CYCLES(DEB), .SETTLE_CYCLES(SETTLE), .WATER_CYCLES(WATER)
  ) dut (
    .clock(clock), .reset_n(reset_n), .H(H), .M(M), .L(L), .Us(Us), .T(T),
    .Ve(Ve), .Al(Al), .Bs(Bs), .Vs(Vs), .zone_valve(zone_valve),
    .active_zone(active_zone), .level(level), .err(err), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic model_reset();
    m_pipe = '{};
    m_pipe.push_back('0);
    m_pipe.push_back('0);
    m_db = '0;
    foreach (m_diff[b]) m_diff[b] = 0;
    m_lvl  = 0;
    m_err  = 1'b0;
    m_ve   = 1'b0;
    m_al   = 1'b1;
    m_busy = 1'b0;
    m_drip = 1'b0;
    m_zone = 0;
    m_last = N - 1;
    m_age  = 0;
    m_wend = -1;
  endtask

  function automatic bit m_eligible(int z);
    return m_db[3 + z] && !m_err && (m_lvl >= (m_db[3 + N + z] ? 1 : 2));
  endfunction

  // One clock edge of the model; everything reads values from before the edge.
  task automatic model_step();
    logic [NB-1:0] raw_now;
    int  code, new_lvl, z;
    bit  new_err, new_ve, found;
    if (!reset_n) begin
      model_reset();
      m_rel = 0;
      return;
    end
    if (m_rel < 2) begin
      m_rel++;
      return;
    end
    raw_now = {T, Us, H, M, L};

    if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        z = (m_last + k) % N;
        if (!found && m_eligible(z)) begin
          found  = 1'b1;
          m_busy = 1'b1;
          m_zone = z;
          m_drip = m_db[3 + N + z];
          m_age  = 0;
          m_wend = -1;
        end
      end
    end else if (m_age < SETTLE) begin
      m_age++;
    end else if (m_wend < 0) begin
      if ((m_age - SETTLE + 1 >= WATER) || !m_db[3 + m_zone] || m_err ||
          (m_lvl < (m_drip ? 1 : 2)))
        m_wend = m_age + 1;
      m_age++;
    end else if (m_age == m_wend + SETTLE - 1) begin
      m_busy = 1'b0;
      m_last = m_zone;
    end else begin
      m_age++;
    end

    code    = int'({m_db[2], m_db[1], m_db[0]});
    new_err = 1'b0;
    new_lvl = m_lvl;
    case (code)
      0: new_lvl = 0;
      1: new_lvl = 1;
      3: new_lvl = 2;
      7: new_lvl = 3;
      default: new_err = 1'b1;
    endcase
    new_ve = m_ve;
    if (new_err)           new_ve = 1'b0;
    else if (new_lvl <= 1) new_ve = 1'b1;
    else if (new_lvl == 3) new_ve = 1'b0;
    m_al  = (new_lvl == 0) || new_err;
    m_lvl = new_lvl;
    m_err = new_err;
    m_ve  = new_ve;

    for (int b = 0; b < NB; b++) begin
      if (m_pipe[0][b] != m_db[b]) begin
        m_diff[b]++;
        if (m_diff[b] == DEB) begin
          m_db[b]   = m_pipe[0][b];
          m_diff[b] = 0;
        end
      end else begin
        m_diff[b] = 0;
      end
    end
    void'(m_pipe.pop_front());
    m_pipe.push_back(raw_now);
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic checkOutput();
    logic [N-1:0] exp_zv;
    bit pumping;
    pumping = m_busy && (m_age >= SETTLE) && (m_wend < 0);
    exp_zv  = m_busy ? (N'(1) << m_zone) : '0;
    check_val("zone_valve",  8'(zone_valve),  8'(exp_zv));
    check_val("active_zone", 8'(active_zone), m_busy ? 8'(m_zone) : 8'd0);
    check_val("busy",        8'(busy),        8'(m_busy));
    check_val("Bs",          8'(Bs),          8'(pumping && !m_drip));
    check_val("Vs",          8'(Vs),          8'(pumping && m_drip));
    check_val("level",       8'(level),       8'(m_lvl));
    check_val("err",         8'(err),         8'(m_err));
    check_val("Ve",          8'(Ve),          8'(m_ve));
    check_val("Al",          8'(Al),          8'(m_al));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [2:0] hml, input logic [N-1:0] us,
                               input logic [N-1:0] t, input int n);
    {H, M, L} = hml;
    Us = us;
    T  = t;
    repeat (n) tick();
  endtask

  task automatic pulse_reset(input int n_low);
    reset_n = 1'b0;
    model_reset();
    m_rel = 0;
    #1 checkOutput();
    repeat (n_low) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [2:0] hml;
    {H, M, L} = 3'b111;
    Us = '0;
    T  = '0;
    #1 reset_n = 1'b0;
    model_reset();
    m_rel = 0;
    repeat (3) tick();
    reset_n = 1'b1;

    $display("[TB] full tank, no requests, short L glitch");
    applyStimulus(3'b111, 4'b0000, 4'b0000, 15);
    applyStimulus(3'b110, 4'b0000, 4'b0000, 3);
    applyStimulus(3'b111, 4'b0000, 4'b0000, 10);

    $display("[TB] zone 0 sprinkler then zone 2 drip");
    applyStimulus(3'b111, 4'b0101, 4'b0100, 50);

    $display("[TB] medium tank, level drops to low mid-water");
    applyStimulus(3'b011, 4'b0000, 4'b0000, 20);
    applyStimulus(3'b011, 4'b0001, 4'b0000, 12);
    applyStimulus(3'b001, 4'b0001, 4'b0000, 20);

    $display("[TB] invalid level code during watering");
    applyStimulus(3'b111, 4'b0001, 4'b0000, 14);
    applyStimulus(3'b101, 4'b0001, 4'b0000, 15);
    applyStimulus(3'b111, 4'b0000, 4'b0000, 25);

    $display("[TB] zone 1 request withdrawn while watering");
    applyStimulus(3'b111, 4'b0010, 4'b0000, 6);
    applyStimulus(3'b111, 4'b0000, 4'b0000, 12);
    applyStimulus(3'b111, 4'b0010, 4'b0000, 30);

    $display("[TB] reset in the middle of a visit");
    applyStimulus(3'b111, 4'b0011, 4'b0000, 12);
    pulse_reset(2);
    applyStimulus(3'b111, 4'b0011, 4'b0000, 40);

    $display("[TB] randomized sensor activity");
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 4) != 0) hml = 3'(valid_codes[$urandom_range(0, 3)]);
      else                           hml = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) pulse_reset($urandom_range(1, 3));
      applyStimulus(hml, N'($urandom), N'($urandom), $urandom_range(1, 14));
    end
    applyStimulus(3'b111, 4'b1111, 4'b1010, 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rega_multizona.md
# rega_multizona

Multi-zone successor to the single-bed irrigation controller: one shared tank and pump serve `N_ZONES` beds, one at a time, under a round-robin scheduler. The block debounces all sensors and decodes tank level with error detection. It drives the tank fill valve and alarm, and sequences zone valves with sprinkler or drip mode per zone. It sits between the raw sensor pins and the display/matrix status logic, replacing the combinational level/irrigation path.

## Interface
- `N_ZONES`, 4: number of beds (2..8).
- `DEB_CYCLES`, 16: cycles an input must be stable before it is accepted (≥2).
- `SETTLE_CYCLES`, 8: valve open/close settle time before and after pumping (≥1).
- `WATER_CYCLES`, 1000: maximum pumping time per zone visit (≥1).
- `clock` in 1: system clock; single clock domain.
- `reset_n` in 1: asynchronous active-low reset.
- `H`, `M`, `L` in 1 each: tank level sensors (1 = water at or above the sensor).
- `Us` in N_ZONES: per-zone soil dry (1 = needs water).
- `T` in N_ZONES: per-zone high temperature (1 = hot, selects drip).
- `Ve` out 1: tank fill valve.
- `Al` out 1: alarm.
- `Bs` out 1: sprinkler pump.
- `Vs` out 1: drip valve.
- `zone_valve` out N_ZONES: one-hot zone valve enables.
- `active_zone` out $clog2(N_ZONES): zone currently owned by the sequencer.
- `level` out 2: 0 critical, 1 low, 2 medium, 3 high.
- `err` out 1: invalid level code.
- `busy` out 1: sequencer not idle.

## Operation
- Every input passes a 2-FF synchroniser, then a per-bit debouncer. The accepted value updates only after the synchronised value has differed from it for `DEB_CYCLES` consecutive cycles.
- Level decode of {H,M,L}:
  - 000 → critical
  - 001 → low
  - 011 → medium
  - 111 → high
  - Any other code sets `err=1` and holds `level` at its last valid value.
- `Ve` has hysteresis: it sets when level ≤ low and `err=0`, and clears when level = high or `err=1`.
- `Al` = critical OR `err`.
- Zone i requests when debounced `Us[i]`=1.
  - If `T[i]`=1, the zone uses drip mode and needs level ≥ low.
  - Otherwise it uses sprinkler mode and needs level ≥ medium.
  - The request is eligible only if the level condition holds and `err=0`.
- FSM states and transitions:
  - IDLE: if any zone is eligible, pick the first eligible zone searching from `last+1` modulo N_ZONES, latch the zone and its mode, and go to OPEN.
  - OPEN: assert `zone_valve[z]` and count `SETTLE_CYCLES`, then go to WATER.
  - WATER: keep the valve on and assert `Bs` or `Vs` according to the latched mode. Go to CLOSE on the first of these:
    - the count reaches `WATER_CYCLES`;
    - `Us[z]` clears;
    - the zone becomes ineligible;
    - `err` is asserted.
  - CLOSE: drop `Bs`/`Vs` immediately, keep the valve on for `SETTLE_CYCLES`, then clear it, set `last=z`, and go to IDLE.
- The latched mode does not change during a visit; a `T` change takes effect at the next visit.
- `Bs` and `Vs` are never both 1. At most one `zone_valve` bit is set. Pumping occurs only in WATER.
- `busy` = state ≠ IDLE.

## Timing
- Reset values:
  - all outputs 0, except `level`=0 (critical) and `Al`=1;
  - debouncers load 0;
  - `last` = N_ZONES−1, so zone 0 is searched first.
- Input to accepted-value latency is 2 + `DEB_CYCLES` cycles.
- Decoded outputs `level`, `err`, `Ve`, `Al` are registered, 1 cycle after the debounced value.
- IDLE→OPEN is 1 cycle after eligibility.
- A visit to the timeout lasts `SETTLE_CYCLES` + `WATER_CYCLES` + `SETTLE_CYCLES` cycles, plus 1 cycle back in IDLE.
- An abort condition seen in WATER cycle k drops the pump in cycle k+1.
- Counters are sized $clog2(max+1), saturate, and reset on every state entry.
- Round-robin wraps from N_ZONES−1 to 0.
- If several zones request simultaneously, the lowest index after `last` wins.
- `reset_n` asserted mid-visit closes the valve and pump asynchronously. Release is synchronised internally with a 2-FF deassert.

## Structure
- Package `rega_pkg` holds:
  - level enum (CRIT, BAIXO, MEDIO, ALTO);
  - FSM state enum (IDLE, OPEN, WATER, CLOSE);
  - mode enum (ASPERSAO, GOTEJAMENTO).
- One sub-module, `debounce_sync` (sync + stable counter, `DEB_CYCLES` parameter), instantiated once per input bit.
- The scheduler and FSM stay in the top.

## Test plan
Use `N_ZONES`=4, `DEB_CYCLES`=4, `SETTLE_CYCLES`=2, `WATER_CYCLES`=10.
- Reset, level 111, `Us`=0000 → `Ve`=0, `Al`=0, `level`=3, `busy`=0. A 3-cycle pulse on `L` is ignored.
- Level 111, `Us`=0101, `T`=0100 →
  - zone 0 sprinkler: `Bs`=1 for 10 cycles;
  - then zone 2 drip: `Vs`=1;
  - `zone_valve` is 0001 then 0100, each framed by 2-cycle settles.
- Level 011, `Us`=0001, `T`=0 → sprinkler zone 0 runs. Drop to 001 mid-WATER → `Bs` falls 1 cycle after the debounced level, `Ve`=1.
- Level code 101 → `err`=1, `Al`=1, `Ve`=0, any WATER aborts, `level` keeps its previous value.
- `Us[1]` clears in WATER cycle 3 → CLOSE, `Bs`=0 next cycle. The next request from zone 1 only is served again after IDLE.
- `reset_n` low during WATER → `zone_valve`, `Bs`, `Vs` = 0 immediately. After release, zone 0 is searched first.
